// File: rtl/fabric_rr_arbiter.sv
// Packet-locked round-robin arbiter that drives the one-hot grant of the 8-port switch fabric.
// Optional stall watchdog is compiled in with the FABRIC_ARB_WDOG_EN macro.
module fabric_rr_arbiter #(
    parameter int unsigned ADDR_W     = 4,
    parameter logic [7:0]  WDOG_LIMIT = 8'd255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        req,
    input  logic [7:0]        eop,
    input  logic [ADDR_W-1:0] addr [7:0],
    input  logic [7:0]        out_ready,
    output logic [7:0]        grant,
    output logic              xfer,
    output logic              busy,
    output logic [2:0]        grant_idx
`ifdef FABRIC_ARB_WDOG_EN
    ,
    output logic              wdog_fire
`endif
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_grant_idx;
    logic [2:0] w_grant_idx_nxt;
    logic [2:0] r_rr_ptr;
    logic [2:0] w_rr_ptr_nxt;
    logic [2:0] r_ldst;
    logic [2:0] w_ldst_nxt;
    logic [7:0] w_eligible;
    logic       w_found;
    logic [2:0] w_winner;
    logic [2:0] w_cand;
    logic       w_locked;
    logic       w_release;

    assign w_locked = (r_state == ST_LOCKED);

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w_eligible[i] = req[i] & out_ready[addr[i][2:0]];
        end
    end

    // First eligible input at or above the rotating pointer, wrapping 7 -> 0.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        w_found  = 1'b0;
        w_winner = 3'd0;
        w_cand   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            w_cand = r_rr_ptr + 3'(k);
            if (!w_found && w_eligible[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    // The locked destination, not the live address, qualifies every beat of the packet.
    assign xfer = w_locked & req[r_grant_idx] & out_ready[r_ldst];

`ifdef FABRIC_ARB_WDOG_EN
    logic [7:0] r_wdog_cnt;
    logic       w_wdog_fire;

    assign w_wdog_fire = w_locked & ~xfer & (r_wdog_cnt == WDOG_LIMIT - 8'd1);
    assign wdog_fire   = w_wdog_fire;
    assign w_release   = (xfer & eop[r_grant_idx]) | w_wdog_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog_cnt <= 8'd0;
        end else if (!w_locked || xfer) begin
            r_wdog_cnt <= 8'd0;
        end else begin
            r_wdog_cnt <= r_wdog_cnt + 8'd1;
        end
    end
`else
    logic w_unused_cfg;

    assign w_release    = xfer & eop[r_grant_idx];
    assign w_unused_cfg = ^WDOG_LIMIT;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_grant_idx_nxt = r_grant_idx;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_ldst_nxt      = r_ldst;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt     = ST_LOCKED;
                    w_grant_idx_nxt = w_winner;
                    w_ldst_nxt      = addr[w_winner][2:0];
                end
            end
            ST_LOCKED: begin
                if (w_release) begin
                    w_state_nxt     = ST_IDLE;
                    w_grant_idx_nxt = 3'd0;
                    w_rr_ptr_nxt    = r_grant_idx + 3'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant_idx <= 3'd0;
            r_rr_ptr    <= 3'd0;
            r_ldst      <= 3'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_ldst      <= w_ldst_nxt;
        end
    end

    // Outputs decode straight from state, so an asynchronous reset drops the grant at once.
    assign busy      = w_locked;
    assign grant     = w_locked ? (8'b1 << r_grant_idx) : 8'b0;
    assign grant_idx = r_grant_idx;

    // Destination bits above [2:0] carry no routing meaning here.
    generate
        if (ADDR_W > 3) begin : g_unused_addr
            logic w_unused_addr;
            always_comb begin
                w_unused_addr = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    w_unused_addr = w_unused_addr ^ (^addr[i][ADDR_W-1:3]);
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_fabric_rr_arbiter.sv
// Self-checking bench for fabric_rr_arbiter: directed scenarios followed by random traffic,
// all compared against a packet-level reference model of the arbitration rules.
module tb_fabric_rr_arbiter;

    localparam int LIM = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] eop;
    logic [3:0] addr [7:0];
    logic [7:0] out_ready;
    logic [7:0] grant;
    logic       xfer;
    logic       busy;
    logic [2:0] grant_idx;
`ifdef FABRIC_ARB_WDOG_EN
    logic       wdog_fire;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model: owner is the input holding the fabric (-1 when idle).
    int m_owner;
    int m_ptr;
    int m_ldst;
    int m_stall;
    int n_xfer;
    int n_fire;
    int n_idle_grants;

    fabric_rr_arbiter #(
        .ADDR_W     (4),
        .WDOG_LIMIT (8'(LIM))
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .eop       (eop),
        .addr      (addr),
        .out_ready (out_ready),
        .grant     (grant),
        .xfer      (xfer),
        .busy      (busy),
        .grant_idx (grant_idx)
`ifdef FABRIC_ARB_WDOG_EN
        ,
        .wdog_fire (wdog_fire)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_ldst  = 0;
        m_stall = 0;
    endtask

    // Called at a falling edge with inputs already applied; checks, advances the model, waits one cycle.
    task automatic step();
        logic [7:0] e_grant;
        logic       e_xfer;
        logic       e_fire;
        logic       e_release;
        #1;
        e_grant = (m_owner < 0) ? 8'h00 : 8'(1 << m_owner);
        e_xfer  = (m_owner >= 0) && req[m_owner] && out_ready[m_ldst];
        e_fire  = 1'b0;
`ifdef FABRIC_ARB_WDOG_EN
        e_fire  = (m_owner >= 0) && !e_xfer && (m_stall == LIM - 1);
        check("wdog_fire", 32'(wdog_fire), 32'(e_fire));
        if (wdog_fire) n_fire++;
`endif
        check("grant", 32'(grant), 32'(e_grant));
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("grant_idx", 32'(grant_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        check("xfer", 32'(xfer), 32'(e_xfer));
        check("onehot0", 32'($onehot0(grant)), 32'd1);
        if (xfer) n_xfer++;
        if (m_owner < 0) begin
            m_stall = 0;
            for (int k = 0; k < 8; k++) begin
                int i;
                i = (m_ptr + k) % 8;
                if (m_owner < 0 && req[i] && out_ready[addr[i][2:0]]) begin
                    m_owner = i;
                    m_ldst  = int'(addr[i][2:0]);
                end
            end
        end else begin
            e_release = (e_xfer && eop[m_owner]) || e_fire;
            m_stall   = e_xfer ? 0 : m_stall + 1;
            if (e_release) begin
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end
        end
        @(negedge clk);
    endtask

    // Asserted away from any clock edge so the checks see the asynchronous effect.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 8'h00;
        eop       = 8'h00;
        out_ready = 8'hFF;
        for (int i = 0; i < 8; i++) addr[i] = 4'd0;
        model_reset();
        n_xfer = 0;
        n_fire = 0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_idx", 32'(grant_idx), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_xfer", 32'(xfer), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Single-beat packet from input 0.
        req = 8'h01; addr[0] = 4'd3; eop = 8'h01; out_ready = 8'hFF;
        step();
        step();
        req = 8'h00;
        step();
        step();

        // All inputs requesting single-beat packets: rotation starts at input 1.
        req = 8'hFF; eop = 8'hFF;
        for (int i = 0; i < 8; i++) addr[i] = 4'(i);
        n_idle_grants = 0;
        for (int c = 0; c < 18; c++) begin
            if (c == 1) check("rotate_first", 32'(grant), 32'h02);
            if (c == 15) check("rotate_last", 32'(grant), 32'h01);
            step();
        end
        req = 8'h00; eop = 8'h00;
        step();

        // Four-beat packet on input 2 with a destination stall and a mid-packet address change.
        do_reset();
        req = 8'h04; addr[2] = 4'd6; out_ready = 8'hFF;
        n_xfer = 0;
        step();
        step();
        step();
        addr[2] = 4'd1; out_ready = 8'hBF;
        for (int c = 0; c < 3; c++) begin
            check("stall_hold", 32'(grant), 32'h04);
            step();
        end
        out_ready = 8'hFF;
        step();
        eop = 8'h04;
        step();
        req = 8'h00; eop = 8'h00;
        step();
        check("pkt_xfers", 32'(n_xfer), 32'd4);

        // Input 0 blocked by its destination, so input 4 wins despite the pointer at 0.
        do_reset();
        req = 8'h11; eop = 8'h11; addr[0] = 4'd5; addr[4] = 4'd1; out_ready = 8'hDF;
        step();
        check("skip_blocked", 32'(grant), 32'h10);
        step();
        req = 8'h00; eop = 8'h00; out_ready = 8'hFF;
        step();

        // Reset while locked mid-packet, then arbitration restarts from input 0.
        req = 8'h01; addr[0] = 4'd2;
        step();
        step();
        step();
        #2;
        do_reset();
        req = 8'h03; eop = 8'h03; addr[1] = 4'd4;
        step();
        check("post_rst_grant", 32'(grant), 32'h01);
        step();
        req = 8'h00; eop = 8'h00;
        step();

`ifdef FABRIC_ARB_WDOG_EN
        // Granted input drops its request; the watchdog must release and pass the grant on.
        do_reset();
        req = 8'h05; addr[0] = 4'd0; addr[2] = 4'd2; out_ready = 8'hFF; eop = 8'h00;
        n_fire = 0;
        step();
        step();
        req = 8'h04;
        for (int c = 0; c < 8; c++) step();
        check("wdog_fires", 32'(n_fire), 32'd1);
        req = 8'h00;
        do_reset();
`endif

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            req       = 8'($urandom) & 8'($urandom);
            eop       = 8'($urandom_range(0, 3) == 0 ? $urandom : 0);
            out_ready = 8'($urandom) | 8'($urandom);
            for (int i = 0; i < 8; i++) addr[i] = 4'($urandom);
            step();
        end
        req = 8'h00;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fabric_rr_arbiter.md
Name: fabric_rr_arbiter

Overview:
- Round-robin packet arbiter that drives the one-hot `grant` input of the 8-port switch fabric.
- Selects one of 8 requesting inputs whose destination output is ready.
- Locks the grant for the whole packet, until the end-of-packet beat transfers.
- Rotates priority on packet completion so every input gets fair access to the single shared fabric path.

Parameters:
- ADDR_W, 4, width of each per-input destination address; only bits [2:0] select the output port.
- WDOG_LIMIT, 255, maximum cycles a grant may stall without a transfer (used only with the optional feature); 8-bit value, must be at least 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  8  per-input request; req[i]=1 means input i presents a valid beat.
- eop  input  8  per-input end-of-packet flag; qualified by req[i].
- addr  input  ADDR_W x 8 (unpacked [7:0])  per-input destination; [2:0] = output port.
- out_ready  input  8  per-output ready from the downstream output buffers.
- grant  output  8  one-hot grant to the fabric; all-zero when idle.
- xfer  output  1  beat transfer strobe this cycle; combinational.
- busy  output  1  1 while in LOCKED state.
- grant_idx  output  3  binary index of the current grant; 0 when idle.

Behaviour:
- Reset: grant=0, grant_idx=0, busy=0, rr_ptr=0, locked destination=0, state=IDLE; xfer=0. Reset asserted mid-packet drops the grant immediately, with no completion.
- Eligibility: eligible[i] = req[i] & out_ready[addr[i][2:0]].

IDLE state:
- If any eligible[i], pick the first eligible index searching upward from rr_ptr, wrapping 7 to 0.
- Next cycle: grant=one-hot(winner), grant_idx=winner, busy=1, state=LOCKED.
- Latch addr[winner][2:0] as the locked destination `ldst`.
- If nothing is eligible, stay in IDLE with grant=0.
- Arbitration latency: eligible request in cycle N gives grant visible in cycle N+1.

LOCKED state (g = grant_idx):
- xfer = req[g] & out_ready[ldst]. Combinational; no transfer occurs while grant=0.
- Changes on addr[g] after grant are ignored; `ldst` is used for the whole packet.
- req[g]=0 or out_ready[ldst]=0: hold the grant and stall; xfer=0.
- xfer & eop[g]: release. Next cycle grant=0, busy=0, state=IDLE, rr_ptr=(g+1) mod 8.
- Requests from other inputs have no effect while LOCKED.

Other rules:
- Single-beat packet: the first beat carries eop; the grant is held for exactly 1 cycle.
- One idle bubble after every release: the next grant is visible 2 cycles after the eop beat. This is the fixed turnaround.
- rr_ptr moves only on release, never on a stall.
- grant is always zero or exactly one-hot, never multi-hot.

Optional Feature:
- Macro: FABRIC_ARB_WDOG_EN.
- When defined:
  - An 8-bit stall counter clears on every xfer and on entry to LOCKED, and increments on each LOCKED cycle without xfer.
  - When the counter reaches WDOG_LIMIT, the grant is force-released exactly as on eop (rr_ptr=g+1).
  - A 1-cycle output pulse wdog_fire asserts in the cycle the force-release is decided.
  - The counter resets to 0 on rst.
- When not defined: no counter, no wdog_fire port, and the grant is held indefinitely until eop.

Test Plan:
- Reset then req=8'h01, addr[0]=3, out_ready=8'hFF, eop=1 -> grant=8'h01 one cycle after req; xfer=1 for one cycle; grant=0 next cycle; rr_ptr=1.
- req=8'hFF held, all eop=1, all ready -> grants rotate 01,02,04,...,80,01 with one idle cycle between grants.
- Input 2 granted, 4-beat packet, out_ready[ldst] dropped for 3 cycles after beat 2, and addr[2] changed mid-packet -> grant stays 8'h04; xfer=0 during the stall; 4 xfers total; release only on the eop beat.
- req=8'h11 with out_ready blocking input 0's destination -> input 4 granted even though rr_ptr=0.
- rst asserted while LOCKED mid-packet -> grant=0 and busy=0 immediately (asynchronous); after deassert rr_ptr=0 and arbitration restarts.
- With FABRIC_ARB_WDOG_EN and WDOG_LIMIT=4: granted input stalls with req=0 -> wdog_fire after 4 stall cycles, grant=0 next cycle, next requester granted.
